// File: rtl/psum_accumulator.sv
// Partial-sum accumulator / requantize stage: sums ACC_LEN signed beats, shifts, saturates, registers result.
// Optional ReLU on the output stage when PSUM_ACCUMULATOR_RELU_EN is defined.
module psum_accumulator #(
  parameter int unsigned IN_WIDTH  = 19,
  parameter int unsigned ACC_LEN   = 9,
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned SHIFT     = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic signed [IN_WIDTH-1:0]          in_psum,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic signed [OUT_WIDTH-1:0]         out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [$clog2(ACC_LEN+1)-1:0]        beat_cnt
);

  localparam int unsigned ACC_WIDTH = IN_WIDTH + $clog2(ACC_LEN);
  localparam int unsigned CNT_WIDTH = $clog2(ACC_LEN + 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    ACC_WIDTH'((longint'(1) << (OUT_WIDTH - 1)) - longint'(1));
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    ACC_WIDTH'(-(longint'(1) << (OUT_WIDTH - 1)));

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_e;

  state_e                        state_q, state_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_WIDTH-1:0]          cnt_q, cnt_d;
  logic signed [OUT_WIDTH-1:0]   out_data_q, out_data_d;

  logic signed [ACC_WIDTH-1:0]   psum_ext;
  logic signed [ACC_WIDTH-1:0]   sum_c;
  logic signed [ACC_WIDTH-1:0]   shifted_c;
  logic signed [OUT_WIDTH-1:0]   sat_c;
  logic signed [OUT_WIDTH-1:0]   result_c;
  logic                          accept;
  logic                          out_xfer;
  logic                          last_beat;

  assign in_ready  = (state_q == ACCUM) || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_xfer  = (state_q == HOLD) && out_ready;
  assign last_beat = (cnt_q == CNT_WIDTH'(ACC_LEN - 1));

  // First beat of a group loads instead of adding, so no clear cycle is needed.
  assign psum_ext  = ACC_WIDTH'(in_psum);
  assign sum_c     = (cnt_q == '0) ? psum_ext : acc_q + psum_ext;
  assign shifted_c = sum_c >>> SHIFT;

  always_comb begin
    sat_c = OUT_WIDTH'(shifted_c);
    if (shifted_c > SAT_MAX) begin
      sat_c = OUT_WIDTH'(SAT_MAX);
    end else if (shifted_c < SAT_MIN) begin
      sat_c = OUT_WIDTH'(SAT_MIN);
    end
  end

`ifdef PSUM_ACCUMULATOR_RELU_EN
  assign result_c = sat_c[OUT_WIDTH-1] ? '0 : sat_c;
`else
  assign result_c = sat_c;
`endif

  // HOLD is exactly the out_valid condition.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    if (out_xfer) begin
      state_d = ACCUM;
    end
    if (accept) begin
      if (last_beat) begin
        out_data_d = result_c;
        state_d    = HOLD;
        cnt_d      = '0;
      end else begin
        acc_d = sum_c;
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ACCUM;
      acc_q      <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign out_data  = out_data_q;
  assign beat_cnt  = cnt_q;

endmodule
